sna_request: RTL and testbench

SNA_REQUEST -- requirements
Module: sna_request

---
 rtl/sna_pkg.sv | 30 +++
 rtl/sna_flit_decode.sv | 17 +
 rtl/sna_request.sv | 178 +++++++++++++++++
 tb/tb_sna_request.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sna_pkg.sv
// Shared SNA definitions: flit field layout, flit type codes and request FSM states.
// Used by the request path, the response path and the tests.
package sna_pkg;

    localparam int SNA_FLIT_W = 37;
    localparam int TYPE_MSB   = 36;
    localparam int TYPE_LSB   = 35;
    localparam int VC_MSB     = 34;
    localparam int VC_LSB     = 32;
    localparam int VC_W       = VC_MSB - VC_LSB + 1;
    localparam int PAYLOAD_W  = 32;

    typedef enum logic [1:0] {
        FLIT_HDR_RD = 2'b00,
        FLIT_HDR_WR = 2'b01,
        FLIT_BODY   = 2'b10,
        FLIT_TAIL   = 2'b11
    } flit_type_e;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_TAIL_R = 3'd1,
        ST_WAIT_BODY   = 3'd2,
        ST_WAIT_TAIL_W = 3'd3,
        ST_ISSUE_AR    = 3'd4,
        ST_ISSUE_W     = 3'd5,
        ST_WAIT_RESP   = 3'd6
    } sna_state_e;

endpackage

// File: rtl/sna_flit_decode.sv
// Combinational split of a NoC flit into type, VC id and payload.
module sna_flit_decode
    import sna_pkg::*;
#(
    parameter int FLIT_W = SNA_FLIT_W
) (
    input  logic [FLIT_W-1:0]    flit,
    output flit_type_e           ftype,
    output logic [VC_W-1:0]      vc,
    output logic [PAYLOAD_W-1:0] payload
);

    assign ftype   = flit_type_e'(flit[TYPE_MSB:TYPE_LSB]);
    assign vc      = flit[VC_MSB:VC_LSB];
    assign payload = flit[PAYLOAD_W-1:0];

endmodule

// File: rtl/sna_request.sv
// SNA request path: collects a NoC read/write packet and issues it as one AXI4-Lite
// request, holding off the NoC until the response path reports completion.
module sna_request
    import sna_pkg::*;
#(
    parameter int FLIT_W = SNA_FLIT_W,
    parameter int ADDR_W = 32,
    parameter int NUM_VC = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [FLIT_W-1:0] noc_data,
    input  logic              is_valid,
    output logic [NUM_VC-1:0] is_on_off,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic              resp_done,
    output logic [2:0]        req_vc,
    output logic              req_is_write,
    output logic              proto_err
);

    flit_type_e           ftype;
    logic [VC_W-1:0]      fvc;
    logic [PAYLOAD_W-1:0] payload;

    sna_flit_decode #(.FLIT_W(FLIT_W)) u_decode (
        .flit    (noc_data),
        .ftype   (ftype),
        .vc      (fvc),
        .payload (payload)
    );

    sna_state_e        state, nxt_state;
    logic [ADDR_W-1:0] nxt_awaddr, nxt_araddr, nxt_wdata;
    logic [3:0]        nxt_wstrb;
    logic [2:0]        nxt_req_vc;
    logic              nxt_req_is_write;
    logic              nxt_awvalid, nxt_wvalid, nxt_arvalid, nxt_err;
    logic              vc_match;

    assign awprot   = 3'b000;
    assign arprot   = 3'b000;
    assign vc_match = (fvc == req_vc);

    always_comb begin
        case (state)
            ST_IDLE, ST_WAIT_TAIL_R, ST_WAIT_BODY, ST_WAIT_TAIL_W: is_on_off = '1;
            default:                                               is_on_off = '0;
        endcase
    end

    always_comb begin
        nxt_state        = state;
        nxt_awaddr       = awaddr;
        nxt_araddr       = araddr;
        nxt_wdata        = wdata;
        nxt_wstrb        = wstrb;
        nxt_req_vc       = req_vc;
        nxt_req_is_write = req_is_write;
        nxt_awvalid      = awvalid;
        nxt_wvalid       = wvalid;
        nxt_arvalid      = arvalid;
        nxt_err          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_valid) begin
                    if (ftype == FLIT_HDR_RD || ftype == FLIT_HDR_WR) begin
                        nxt_req_vc       = fvc;
                        nxt_req_is_write = (ftype == FLIT_HDR_WR);
                        if (ftype == FLIT_HDR_WR) begin
                            nxt_awaddr = ADDR_W'(payload);
                            nxt_state  = ST_WAIT_BODY;
                        end else begin
                            nxt_araddr = ADDR_W'(payload);
                            nxt_state  = ST_WAIT_TAIL_R;
                        end
                    end else begin
                        nxt_err = 1'b1;
                    end
                end
            end
            ST_WAIT_TAIL_R: begin
                if (is_valid) begin
                    if (ftype == FLIT_TAIL && vc_match) begin
                        nxt_arvalid = 1'b1;
                        nxt_state   = ST_ISSUE_AR;
                    end else begin
                        nxt_err   = 1'b1;
                        nxt_state = ST_IDLE;
                    end
                end
            end
            ST_WAIT_BODY: begin
                if (is_valid) begin
                    if (ftype == FLIT_BODY && vc_match) begin
                        nxt_wdata = ADDR_W'(payload);
                        nxt_state = ST_WAIT_TAIL_W;
                    end else begin
                        nxt_err   = 1'b1;
                        nxt_state = ST_IDLE;
                    end
                end
            end
            ST_WAIT_TAIL_W: begin
                if (is_valid) begin
                    if (ftype == FLIT_TAIL && vc_match) begin
                        nxt_wstrb   = payload[3:0];
                        nxt_awvalid = 1'b1;
                        nxt_wvalid  = 1'b1;
                        nxt_state   = ST_ISSUE_W;
                    end else begin
                        nxt_err   = 1'b1;
                        nxt_state = ST_IDLE;
                    end
                end
            end
            ST_ISSUE_AR: begin
                nxt_err = is_valid;
                if (arready) begin
                    nxt_arvalid = 1'b0;
                    nxt_state   = ST_WAIT_RESP;
                end
            end
            ST_ISSUE_W: begin
                // Each valid clears on its own handshake; leave once neither remains pending.
                nxt_err     = is_valid;
                nxt_awvalid = awvalid & ~awready;
                nxt_wvalid  = wvalid & ~wready;
                if (!nxt_awvalid && !nxt_wvalid) nxt_state = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                nxt_err = is_valid;
                if (resp_done) nxt_state = ST_IDLE;
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            awaddr       <= '0;
            araddr       <= '0;
            wdata        <= '0;
            wstrb        <= '0;
            req_vc       <= '0;
            req_is_write <= 1'b0;
            awvalid      <= 1'b0;
            wvalid       <= 1'b0;
            arvalid      <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            state        <= nxt_state;
            awaddr       <= nxt_awaddr;
            araddr       <= nxt_araddr;
            wdata        <= nxt_wdata;
            wstrb        <= nxt_wstrb;
            req_vc       <= nxt_req_vc;
            req_is_write <= nxt_req_is_write;
            awvalid      <= nxt_awvalid;
            wvalid       <= nxt_wvalid;
            arvalid      <= nxt_arvalid;
            proto_err    <= nxt_err;
        end
    end

endmodule

// File: tb/tb_sna_request.sv
// Scoreboard bench for sna_request: stimulus pushes expected AXI handshakes and
// error pulses; a negedge monitor pops and compares them as the DUT produces them.
module tb_sna_request;
    import sna_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [36:0] noc_data = '0;
    logic        is_valid = 1'b0;
    logic [7:0]  is_on_off;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot, req_vc;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, arvalid, req_is_write, proto_err;
    logic        awready = 1'b0, wready = 1'b0, arready = 1'b0, resp_done = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        int          hold;
    } exp_t;

    exp_t exp_ar[$];
    exp_t exp_aw[$];
    exp_t exp_w[$];
    int   exp_err = 0;

    sna_request #(.FLIT_W(37), .ADDR_W(32), .NUM_VC(8)) dut (
        .clock(clock), .reset(reset), .noc_data(noc_data), .is_valid(is_valid),
        .is_on_off(is_on_off), .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid),
        .awready(awready), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .resp_done(resp_done), .req_vc(req_vc), .req_is_write(req_is_write),
        .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: one pop per handshake / error-pulse cycle, plus valid hold-length check.
    initial begin : monitor
        int ar_cnt, aw_cnt, w_cnt;
        exp_t e;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
            end else begin
                if (arvalid) begin
                    ar_cnt++;
                    if (arready) begin
                        if (exp_ar.size() == 0) chk("ar_unexpected", 32'(ar_cnt), 32'd0);
                        else begin
                            e = exp_ar.pop_front();
                            chk("araddr", araddr, e.data);
                            chk("ar_hold", 32'(ar_cnt), 32'(e.hold));
                        end
                        ar_cnt = 0;
                    end
                end
                if (awvalid) begin
                    aw_cnt++;
                    if (awready) begin
                        if (exp_aw.size() == 0) chk("aw_unexpected", 32'(aw_cnt), 32'd0);
                        else begin
                            e = exp_aw.pop_front();
                            chk("awaddr", awaddr, e.data);
                            chk("aw_hold", 32'(aw_cnt), 32'(e.hold));
                        end
                        aw_cnt = 0;
                    end
                end
                if (wvalid) begin
                    w_cnt++;
                    if (wready) begin
                        if (exp_w.size() == 0) chk("w_unexpected", 32'(w_cnt), 32'd0);
                        else begin
                            e = exp_w.pop_front();
                            chk("wdata", wdata, e.data);
                            chk("wstrb", 32'(wstrb), 32'(e.strb));
                            chk("w_hold", 32'(w_cnt), 32'(e.hold));
                        end
                        w_cnt = 0;
                    end
                end
                if (proto_err) begin
                    if (exp_err == 0) chk("proto_err_unexpected", 32'd1, 32'd0);
                    else begin
                        checks++;
                        exp_err--;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [1:0] t, input logic [2:0] vc, input logic [31:0] p);
        noc_data = {t, vc, p};
        is_valid = 1'b1;
        tick();
        is_valid = 1'b0;
        noc_data = '0;
    endtask

    task automatic do_read(input logic [2:0] vc, input logic [31:0] addr, input int ar_cyc);
        arready = 1'b0;
        send(FLIT_HDR_RD, vc, addr);
        chk("rd_onoff_recv", 32'(is_on_off), 32'hFF);
        send(FLIT_TAIL, vc, 32'h0);
        chk("rd_onoff_issue", 32'(is_on_off), 32'h00);
        chk("rd_req_vc", 32'(req_vc), 32'(vc));
        chk("rd_req_is_write", 32'(req_is_write), 32'd0);
        chk("rd_arvalid_entry", 32'(arvalid), 32'd1);
        exp_ar.push_back('{addr, 4'h0, ar_cyc});
        for (int c = 1; c <= ar_cyc; c++) begin
            arready = (c == ar_cyc);
            tick();
        end
        arready = 1'b0;
        chk("rd_arvalid_after", 32'(arvalid), 32'd0);
    endtask

    task automatic do_write(input logic [2:0] vc, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_cyc, input int w_cyc);
        awready = 1'b0;
        wready  = 1'b0;
        send(FLIT_HDR_WR, vc, addr);
        send(FLIT_BODY, vc, data);
        send(FLIT_TAIL, vc, {28'h0, strb});
        chk("wr_valids_entry", {30'd0, awvalid, wvalid}, 32'd3);
        chk("wr_req_is_write", 32'(req_is_write), 32'd1);
        exp_aw.push_back('{addr, 4'h0, aw_cyc});
        exp_w.push_back('{data, strb, w_cyc});
        for (int c = 1; c <= ((aw_cyc > w_cyc) ? aw_cyc : w_cyc); c++) begin
            awready = (c == aw_cyc);
            wready  = (c == w_cyc);
            tick();
            chk("wr_valids_progress", {30'd0, awvalid, wvalid},
                {30'd0, (c < aw_cyc), (c < w_cyc)});
        end
        awready = 1'b0;
        wready  = 1'b0;
    endtask

    task automatic finish_resp();
        chk("resp_onoff_wait", 32'(is_on_off), 32'h00);
        tick();
        chk("resp_onoff_still", 32'(is_on_off), 32'h00);
        resp_done = 1'b1;
        tick();
        resp_done = 1'b0;
        chk("resp_onoff_idle", 32'(is_on_off), 32'hFF);
    endtask

    initial begin : stimulus
        #12;
        chk("rst_onoff", 32'(is_on_off), 32'hFF);
        chk("rst_valids", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
        chk("rst_err", 32'(proto_err), 32'd0);
        chk("rst_addr", awaddr | araddr | wdata, 32'd0);
        chk("rst_req", {27'd0, wstrb, req_is_write} | 32'(req_vc), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        tick();

        // Read, arready after two waiting cycles
        do_read(3'd3, 32'h0000_1000, 3);
        finish_resp();

        // Write: W accepted in cycle 1, AW in cycle 4
        do_write(3'd1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF, 4, 1);
        chk("wr_req_vc", 32'(req_vc), 32'd1);
        finish_resp();

        // Write orderings: same-cycle, AW before W
        do_write(3'd6, 32'h0000_2004, 32'h1234_5678, 4'h3, 1, 1);
        finish_resp();
        do_write(3'd0, 32'h0000_2008, 32'hCAFE_F00D, 4'h8, 1, 2);
        finish_resp();

        // Malformed packets; readies held high so a stray valid would handshake
        arready = 1'b1; awready = 1'b1; wready = 1'b1;
        send(FLIT_HDR_WR, 3'd1, 32'h0000_3000);
        exp_err++;
        send(FLIT_TAIL, 3'd1, 32'h0000_000F);
        chk("err_nobody_onoff", 32'(is_on_off), 32'hFF);
        tick();
        chk("err_nobody_pulse_end", 32'(proto_err), 32'd0);

        send(FLIT_HDR_RD, 3'd2, 32'h0000_4000);
        exp_err++;
        send(FLIT_TAIL, 3'd5, 32'h0);
        chk("err_vc_onoff", 32'(is_on_off), 32'hFF);
        tick();
        tick();

        exp_err++;
        send(FLIT_BODY, 3'd0, 32'h0000_0055);
        chk("err_idle_body_onoff", 32'(is_on_off), 32'hFF);
        tick();

        // resp_done while idle is ignored
        resp_done = 1'b1;
        tick();
        resp_done = 1'b0;
        chk("idle_resp_done_onoff", 32'(is_on_off), 32'hFF);

        // Unsolicited flit while waiting for the response
        do_read(3'd4, 32'h0000_5000, 1);
        exp_err++;
        send(FLIT_HDR_RD, 3'd7, 32'h0000_5555);
        chk("unsol_onoff", 32'(is_on_off), 32'h00);
        chk("unsol_req_vc", 32'(req_vc), 32'd4);
        chk("unsol_araddr", araddr, 32'h0000_5000);
        chk("unsol_arvalid", 32'(arvalid), 32'd0);
        finish_resp();

        // Reset while AW is stalled
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        send(FLIT_HDR_WR, 3'd2, 32'h0000_6000);
        send(FLIT_BODY, 3'd2, 32'h0000_0066);
        send(FLIT_TAIL, 3'd2, 32'h0000_000F);
        chk("rstmid_awvalid_before", 32'(awvalid), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstmid_valids_async", {30'd0, awvalid, wvalid}, 32'd0);
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid_onoff", 32'(is_on_off), 32'hFF);
        tick();
        tick();
        chk("rstmid_no_resume", {29'd0, awvalid, wvalid, arvalid}, 32'd0);

        do_read(3'd5, 32'h0000_7000, 2);
        finish_resp();

        tick();
        tick();
        chk("sb_ar_empty", 32'(exp_ar.size()), 32'd0);
        chk("sb_aw_empty", 32'(exp_aw.size()), 32'd0);
        chk("sb_w_empty", 32'(exp_w.size()), 32'd0);
        chk("sb_err_empty", 32'(exp_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
